division_seq: RTL and testbench
===============================

# division_seq

Sequential unsigned restoring divider for the ALU arithmetic group. It performs the inverse operation of the multiply path and produces one quotient bit per cycle by repeated trial subtraction. Results are reported with the same 5-bit flag vector layout used by `addition` and `subtraction`, so the ALU flag mux consumes them unchanged. A start/busy/done handshake lets the ALU control sequencer issue a division and wait for completion.

## Interface
Parameters:
- `width`, default 4: operand, quotient and remainder width in bits (≥2).

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `start`  input  1: request a division; sampled only in IDLE or DONE.
- `A`  input  width: dividend (unsigned); captured on an accepted start.
- `B`  input  width: divisor (unsigned); captured on an accepted start.
- `busy`  output  1: high while iterating (DIV state).
- `done`  output  1: one-cycle pulse; results are valid from this cycle.
- `Q`  output  width: quotient, registered.
- `R`  output  width: remainder, registered.
- `flags`  output  5: flags[4] sign = Q[width-1]; flags[3] zero = ~|Q; flags[2] overflow = divide-by-zero; flags[1] parity = ^Q; flags[0] carry = inexact (|R).

## Operation
- States: IDLE, DIV, DONE.
- IDLE: if start=1 and B≠0, capture A into the dividend shift register and B into the divisor register, clear the partial remainder (width+1 bits) and the quotient register, load the iteration counter with width, then go to DIV. If start=1 and B=0, go directly to DONE with the divide-by-zero result.
- DIV, one iteration per cycle:
  - Form the partial remainder {rem[width-1:0], dividend MSB} and shift the dividend left.
  - Trial-subtract the divisor using a (width+1)-bit subtraction.
  - If the trial result is non-negative, keep the difference and shift 1 into the quotient. Otherwise keep the shifted remainder and shift 0 into the quotient.
  - Decrement the counter. On the last iteration (counter=1), go to DONE and load Q, R and flags.
- DONE: done=1 for this cycle only. Q, R and flags hold their values until the next accepted start completes. Next state is IDLE, unless start=1, which is handled exactly as a start in IDLE.
- Divide-by-zero result: Q = all ones, R = A, flags[2]=1. The other flags are computed from Q and R by the normal rules.
- start in DIV is ignored. A and B are not re-sampled while in DIV.
- All arithmetic is unsigned and modulo 2^(width+1) internally. Q and R never exceed width bits.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, Q=0, R=0, flags=5'b00000; the counter and datapath registers are cleared.
- Reset during DIV aborts the operation. No done pulse follows, and outputs take their reset values at that edge.
- Normal latency: start sampled at edge N gives busy=1 for cycles N+1 through N+width, and done=1 with valid Q/R/flags in cycle N+width+1. busy=0 in the done cycle.
- Divide-by-zero latency: start at edge N gives done=1 in cycle N+1. busy never asserts.
- Back-to-back: a start asserted during the done cycle is accepted, and busy rises the following cycle. Maximum throughput is one result per width+1 cycles.
- busy and done are never high in the same cycle.
- Q, R and flags change only on the edge that enters DONE, or on reset.

## Test plan
(width=4)
- A=13, B=3, start one cycle -> busy high 4 cycles; done in the 5th cycle; Q=4, R=1, flags=5'b00011.
- A=15, B=1 -> Q=15, R=0, flags=5'b10000; then A=2, B=5 -> Q=0, R=2, flags=5'b01001.
- A=9, B=0 -> done the cycle after start, busy stays 0; Q=15, R=9, flags=5'b10101.
- Exhaustive sweep of all A,B in 0..15 with B≠0, using back-to-back starts asserted in the done cycle -> every result matches A/B and A%B; done spacing is exactly 5 cycles.
- start pulsed again mid-DIV with different A/B -> ignored; result corresponds to the first operands; exactly one done pulse.
- rst_n=0 during the 2nd DIV cycle -> next cycle busy=0, done=0, Q=R=0, flags=0; no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/division_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, start/busy/done
// handshake, and results reported with the ALU's shared 5-bit flag layout.
module division_seq #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] Q,
  output logic [width-1:0] R,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [width-1:0] r_dividend;
  logic [width-1:0] r_divisor;
  logic [width-1:0] r_quot;
  logic [width:0]   r_rem;
  logic [CW-1:0]    r_count;
  logic [width-1:0] r_Q;
  logic [width-1:0] r_R;
  logic [4:0]       r_flags;

  logic             w_accept;
  logic             w_zeroDiv;
  logic             w_last;
  logic [width:0]   w_shift;
  logic [width:0]   w_diff;
  logic [width:0]   w_remNext;
  logic [width-1:0] w_quotNext;

  // Flag layout {sign, zero, divide-by-zero, parity, inexact}, shared with add/sub.
  function automatic logic [4:0] mkFlags(input logic [width-1:0] q,
                                         input logic [width-1:0] r,
                                         input logic             dz);
    mkFlags = {q[width-1], ~|q, dz, ^q, |r};
  endfunction

  always_comb begin
    w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    w_zeroDiv  = (B == '0);
    w_last     = (r_count == CW'(1));
    w_shift    = {r_rem[width-1:0], r_dividend[width-1]};
    w_diff     = w_shift - {1'b0, r_divisor};
    // Remainder stays below the divisor, so the MSB of the difference is a clean borrow.
    w_remNext  = w_diff[width] ? w_shift : w_diff;
    w_quotNext = {r_quot[width-2:0], ~w_diff[width]};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        w_next = IDLE;
        if (start) w_next = w_zeroDiv ? DONE : DIV;
      end
      DIV: begin
        if (w_last) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_count    <= '0;
      r_Q        <= '0;
      r_R        <= '0;
      r_flags    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        if (w_zeroDiv) begin
          r_Q     <= {width{1'b1}};
          r_R     <= A;
          r_flags <= mkFlags({width{1'b1}}, A, 1'b1);
        end else begin
          r_dividend <= A;
          r_divisor  <= B;
          r_rem      <= '0;
          r_quot     <= '0;
          r_count    <= CW'(width);
        end
      end else if (r_state == DIV) begin
        r_dividend <= r_dividend << 1;
        r_rem      <= w_remNext;
        r_quot     <= w_quotNext;
        r_count    <= r_count - CW'(1);
        if (w_last) begin
          r_Q     <= w_quotNext;
          r_R     <= w_remNext[width-1:0];
          r_flags <= mkFlags(w_quotNext, w_remNext[width-1:0], 1'b0);
        end
      end
    end
  end

  assign busy  = (r_state == DIV);
  assign done  = (r_state == DONE);
  assign Q     = r_Q;
  assign R     = r_R;
  assign flags = r_flags;

endmodule

// File: tb/tb_division_seq.sv
// Self-checking bench for division_seq (width=4): directed cases, exhaustive back-to-back
// sweep and random operands against a plain-arithmetic reference.
module tb_division_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic [4:0]   flags;

  int vectorCount = 0;
  int missCount   = 0;

  division_seq #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns in the first cycle after the sampling edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    A = a;
    B = b;
    nextCycle();
    start = 1'b0;
  endtask

  // Reference: plain integer division, divide-by-zero gives all-ones quotient and R=A.
  task automatic expectResult(input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] q, output logic [W-1:0] r,
                              output logic [4:0] f);
    int qi, ri;
    logic dz;
    dz = (b == 0);
    qi = dz ? (1 << W) - 1 : int'(a) / int'(b);
    ri = dz ? int'(a) : int'(a) % int'(b);
    q = qi[W-1:0];
    r = ri[W-1:0];
    f = {q[W-1], q == 0, dz, ^q, r != 0};
  endtask

  // Called in the cycle after the start edge; walks the busy window and returns in the done cycle.
  task automatic checkResult(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic [4:0]   f;
    expectResult(a, b, q, r, f);
    if (b != 0) begin
      for (int i = 0; i < W; i++) begin
        checkOutput("busy", busy, 1);
        checkOutput("noDoneWhileBusy", done, 0);
        nextCycle();
      end
    end
    checkOutput("done", done, 1);
    checkOutput("busyInDone", busy, 0);
    checkOutput("Q", Q, q);
    checkOutput("R", R, r);
    checkOutput("flags", flags, f);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstQ", Q, 0);
    checkOutput("rstR", R, 0);
    checkOutput("rstFlags", flags, 0);
    rst_n = 1'b1;
    nextCycle();

    applyStimulus(4'd13, 4'd3);
    checkResult(4'd13, 4'd3);
    checkOutput("flags13by3", flags, 5'b00011);
    nextCycle();
    applyStimulus(4'd15, 4'd1);
    checkResult(4'd15, 4'd1);
    nextCycle();
    nextCycle();
    checkOutput("holdQ", Q, 15);
    checkOutput("holdFlags", flags, 5'b10000);
    applyStimulus(4'd2, 4'd5);
    checkResult(4'd2, 4'd5);
    checkOutput("flags2by5", flags, 5'b01001);
    nextCycle();
    applyStimulus(4'd9, 4'd0);
    checkResult(4'd9, 4'd0);
    checkOutput("flagsDivZero", flags, 5'b10101);
    nextCycle();
    checkOutput("divZeroOnePulse", done, 0);

    // Exhaustive sweep, each start issued in the previous done cycle.
    applyStimulus(4'd0, 4'd1);
    checkResult(4'd0, 4'd1);
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        if (!(a == 0 && b == 1)) begin
          applyStimulus(a[W-1:0], b[W-1:0]);
          checkResult(a[W-1:0], b[W-1:0]);
        end
      end
    end
    nextCycle();

    // A second start mid-iteration must be ignored.
    applyStimulus(4'd13, 4'd3);
    checkOutput("busyMid", busy, 1);
    start = 1'b1;
    A = 4'd7;
    B = 4'd2;
    nextCycle();
    start = 1'b0;
    for (int i = 0; i < W - 1; i++) begin
      checkOutput("busyIgnore", busy, 1);
      nextCycle();
    end
    checkOutput("doneIgnore", done, 1);
    checkOutput("QIgnore", Q, 4);
    checkOutput("RIgnore", R, 1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("singleDone", done, 0);
    end

    // Reset in the second DIV cycle aborts the operation.
    applyStimulus(4'd11, 4'd2);
    nextCycle();
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortQ", Q, 0);
    checkOutput("abortR", R, 0);
    checkOutput("abortFlags", flags, 0);
    for (int i = 0; i < W + 2; i++) begin
      nextCycle();
      checkOutput("abortNoDone", done, 0);
    end
    applyStimulus(4'd11, 4'd2);
    checkResult(4'd11, 4'd2);

    // Random operands, divide-by-zero included, mix of idle gaps and back-to-back.
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) nextCycle();
      applyStimulus(ra, rb);
      checkResult(ra, rb);
    end
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
